// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and helpers for the CORDIC trig engine.
// Holds the arctangent table (Q3.29), the CORDIC gain K (Q2.30), pi constants
// (Q3.29), the FSM state encoding, and helpers that rescale them to narrower widths.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // atan(2^-i) for i = 0..29, Q3.29
  localparam logic signed [31:0] ATAN_TABLE [0:29] = '{
    32'sh1921FB54, 32'sh0ED63382, 32'sh07D6DD7E, 32'sh03FAB753,
    32'sh01FF55BB, 32'sh00FFEAAD, 32'sh007FFD55, 32'sh003FFFAA,
    32'sh001FFFF5, 32'sh000FFFFE, 32'sh0007FFFF, 32'sh0003FFFF,
    32'sh0001FFFF, 32'sh0000FFFF, 32'sh00007FFF, 32'sh00003FFF,
    32'sh00001FFF, 32'sh00000FFF, 32'sh000007FF, 32'sh000003FF,
    32'sh000001FF, 32'sh000000FF, 32'sh0000007F, 32'sh0000003F,
    32'sh0000001F, 32'sh0000000F, 32'sh00000007, 32'sh00000004,
    32'sh00000002, 32'sh00000001
  };

  localparam logic signed [31:0] CORDIC_K = 32'sh26DD3B6A;  // 0.6072529350, Q2.30
  localparam logic signed [31:0] PI       = 32'sh6487ED51;  // Q3.29
  localparam logic signed [31:0] PI_2     = 32'sh3243F6A9;  // Q3.29
  localparam logic signed [31:0] NEG_PI   = 32'sh9B7812AF;  // Q3.29

  // Rescale a 32-bit fixed-point constant to a narrower datapath (same integer bits).
  function automatic logic signed [31:0] scale_q(input logic signed [31:0] v, input int width);
    return v >>> (32 - width);
  endfunction

  // Table entry for a given iteration, rescaled; indices past the table read as zero.
  function automatic logic signed [31:0] atan_q(input logic [4:0] idx, input int width);
    if (idx > 5'd29) return '0;
    return ATAN_TABLE[idx] >>> (32 - width);
  endfunction

  // Gain constant rounded (not truncated) to the narrower fraction width.
  function automatic logic signed [31:0] k_q(input int width);
    if (width >= 32) return CORDIC_K;
    return (CORDIC_K + (32'sd1 <<< (31 - width))) >>> (32 - width);
  endfunction

endpackage

// File: rtl/cordic_stage_comb.sv
// cordic_stage_comb: one combinational CORDIC micro-rotation (rotation mode).
// Ports: x, y, z, i in -> x_rot, y_rot, z_rot out; all WIDTH+2 bits, z in Q3 format.
// Direction follows the sign of z; shifts are arithmetic.
module cordic_stage_comb
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH+1:0] x,
  input  logic signed [WIDTH+1:0] y,
  input  logic signed [WIDTH+1:0] z,
  input  logic        [4:0]       i,
  output logic signed [WIDTH+1:0] x_rot,
  output logic signed [WIDTH+1:0] y_rot,
  output logic signed [WIDTH+1:0] z_rot
);

  logic signed [31:0]      atan32;
  logic signed [WIDTH+1:0] atan_w;
  logic signed [WIDTH+1:0] x_sh;
  logic signed [WIDTH+1:0] y_sh;

  always_comb begin
    atan32 = atan_q(i, WIDTH);
    atan_w = {{2{atan32[WIDTH-1]}}, atan32[WIDTH-1:0]};
    x_sh   = x >>> i;
    y_sh   = y >>> i;
    if (z[WIDTH+1] == 1'b0) begin
      x_rot = x - y_sh;
      y_rot = y + x_sh;
      z_rot = z - atan_w;
    end else begin
      x_rot = x + y_sh;
      y_rot = y - x_sh;
      z_rot = z + atan_w;
    end
  end

endmodule

// File: rtl/cordic_seq.sv
// cordic_seq: iterative CORDIC giving cos/sin of a full-circle angle, one micro-rotation per clock.
// Ports: clk, reset (sync, active-low), start, theta (Q3.(W-3)) in; busy, done, cos_out,
// sin_out (Q2.(W-2)), err out. Done pulses ITERS+1 edges after the accepting edge; start ignored while busy.
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] theta,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] cos_out,
  output logic signed [WIDTH-1:0] sin_out,
  output logic                    err
);

  localparam int ZW = WIDTH + 2;
  localparam logic signed [31:0] PI_S     = scale_q(PI, WIDTH);
  localparam logic signed [31:0] PI_2_S   = scale_q(PI_2, WIDTH);
  localparam logic signed [31:0] NEG_PI_S = scale_q(NEG_PI, WIDTH);
  localparam logic signed [31:0] K_S      = k_q(WIDTH);
  localparam logic [4:0]         LAST     = 5'(ITERS - 1);

  state_t state, state_n;

  logic signed [ZW-1:0]    x_r, y_r, z_r;
  logic signed [ZW-1:0]    x_n, y_n, z_n;
  logic signed [ZW-1:0]    x_rot, y_rot, z_rot;
  logic [4:0]              i_r, i_n;
  logic                    neg_r, neg_n;
  logic                    oor_r, oor_n;
  logic                    busy_n, done_n, err_n;
  logic signed [WIDTH-1:0] cos_n, sin_n;
  logic signed [WIDTH-1:0] x_lo, y_lo;
  logic signed [31:0]      theta32, fold32;
  logic                    fold_hi, fold_lo;

  cordic_stage_comb #(.WIDTH(WIDTH)) u_stage (
    .x     (x_r),
    .y     (y_r),
    .z     (z_r),
    .i     (i_r),
    .x_rot (x_rot),
    .y_rot (y_rot),
    .z_rot (z_rot)
  );

  // Compare against 32-bit constants; the size cast sign-extends theta.
  assign theta32 = 32'(theta);
  assign fold_hi = theta32 > PI_2_S;
  assign fold_lo = theta32 < -PI_2_S;

  // Fold into [-pi/2, pi/2]; the result always fits back in WIDTH bits.
  always_comb begin
    fold32 = theta32;
    if (fold_hi)      fold32 = theta32 - PI_S;
    else if (fold_lo) fold32 = theta32 + PI_S;
  end

  // Negating in WIDTH bits matches negating the wide value then truncating.
  assign x_lo = x_r[WIDTH-1:0];
  assign y_lo = y_r[WIDTH-1:0];

  always_comb begin
    state_n = state;
    x_n     = x_r;
    y_n     = y_r;
    z_n     = z_r;
    i_n     = i_r;
    neg_n   = neg_r;
    oor_n   = oor_r;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = err;
    cos_n   = cos_out;
    sin_n   = sin_out;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = ITER;
          busy_n  = 1'b1;
          x_n     = {2'b00, K_S[WIDTH-1:0]};
          y_n     = '0;
          z_n     = {{2{fold32[WIDTH-1]}}, fold32[WIDTH-1:0]};
          i_n     = '0;
          neg_n   = fold_hi || fold_lo;
          // Out-of-range angles still iterate; the result is discarded at FINISH.
          oor_n   = (theta32 > PI_S) || (theta32 < NEG_PI_S);
        end
      end
      ITER: begin
        x_n = x_rot;
        y_n = y_rot;
        z_n = z_rot;
        i_n = i_r + 5'd1;
        if (i_r == LAST) state_n = FINISH;
      end
      FINISH: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        err_n   = oor_r;
        if (oor_r) begin
          cos_n = '0;
          sin_n = '0;
        end else begin
          cos_n = neg_r ? -x_lo : x_lo;
          sin_n = neg_r ? -y_lo : y_lo;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      x_r     <= '0;
      y_r     <= '0;
      z_r     <= '0;
      i_r     <= '0;
      neg_r   <= 1'b0;
      oor_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      state   <= state_n;
      x_r     <= x_n;
      y_r     <= y_n;
      z_r     <= z_n;
      i_r     <= i_n;
      neg_r   <= neg_n;
      oor_r   <= oor_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
      cos_out <= cos_n;
      sin_out <= sin_n;
    end
  end

endmodule

// File: tb/tb_cordic_seq.sv
// tb_cordic_seq: directed-vector bench for cordic_seq (WIDTH=32, ITERS=24).
// A real-math reference model tracks handshake timing and expected results;
// a negedge process compares every cycle, and directed runs pin literal values.
module tb_cordic_seq;

  localparam int     WIDTH     = 32;
  localparam int     ITERS     = 24;
  localparam longint TOL       = 512;  // 2^-21 in Q2.30 LSBs
  localparam real    SCALE_IN  = 536870912.0;
  localparam real    SCALE_OUT = 1073741824.0;
  localparam real    PI_R      = 3.141592653589793;

  logic               clk   = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic signed [31:0] theta = '0;
  logic               busy, done, err;
  logic signed [31:0] cos_out, sin_out;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // reference model state
  bit                 m_active = 1'b0;
  bit                 m_busy   = 1'b0;
  bit                 m_done   = 1'b0;
  bit                 m_err    = 1'b0;
  bit                 m_exact  = 1'b1;
  int                 m_left   = 0;
  logic signed [31:0] m_theta  = '0;
  longint             m_cos    = 0;
  longint             m_sin    = 0;

  always #5 clk = ~clk;

  cordic_seq #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .theta   (theta),
    .busy    (busy),
    .done    (done),
    .cos_out (cos_out),
    .sin_out (sin_out),
    .err     (err)
  );

  function automatic longint rnd(input real r);
    if (r >= 0.0) return longint'($rtoi(r + 0.5));
    return -longint'($rtoi(-r + 0.5));
  endfunction

  // Model: a request is served for ITERS+1 edges, then the result appears with a one-cycle done.
  always @(posedge clk) begin : model
    real th;
    if (!reset) begin
      m_active <= 1'b0;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_err    <= 1'b0;
      m_exact  <= 1'b1;
      m_cos    <= 0;
      m_sin    <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active <= 1'b1;
          m_busy   <= 1'b1;
          m_left   <= ITERS + 1;
          m_theta  <= theta;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_active <= 1'b0;
          m_busy   <= 1'b0;
          m_done   <= 1'b1;
          th = $itor(m_theta) / SCALE_IN;
          if (th > PI_R || th < -PI_R) begin
            m_err   <= 1'b1;
            m_exact <= 1'b1;
            m_cos   <= 0;
            m_sin   <= 0;
          end else begin
            m_err   <= 1'b0;
            m_exact <= 1'b0;
            m_cos   <= rnd($cos(th) * SCALE_OUT);
            m_sin   <= rnd($sin(th) * SCALE_OUT);
          end
        end
      end
    end
  end

  task automatic chk_bit(input string nm, input logic act, input logic req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0b, want %0b (t=%0t)", nm, act, req, $time);
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req, $time);
  endtask

  task automatic chk_near(input string nm, input longint act, input longint req, input longint tol);
    longint d;
    n_chk++;
    d = act - req;
    if (d < 0) d = -d;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d, want %0d +/- %0d (t=%0t)", nm, act, req, tol, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk_bit("cyc_busy", busy, m_busy);
      chk_bit("cyc_done", done, m_done);
      chk_bit("cyc_err", err, m_err);
      chk_near("cyc_cos", longint'(cos_out), m_cos, m_exact ? 0 : TOL);
      chk_near("cyc_sin", longint'(sin_out), m_sin, m_exact ? 0 : TOL);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // One request with literal expectations for the DUT and for the model itself.
  task automatic run_angle(input string nm, input logic signed [31:0] th,
                           input longint ec, input longint es, input logic ee);
    int n;
    longint tol;
    tol = ee ? 0 : TOL;
    wait_idle();
    theta = th;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
    chk_int({nm, "_latency"}, n, ITERS + 1);
    if (done) begin
      chk_near({nm, "_cos"}, longint'(cos_out), ec, tol);
      chk_near({nm, "_sin"}, longint'(sin_out), es, tol);
      chk_bit({nm, "_err"}, err, ee);
      chk_near({nm, "_model_cos"}, m_cos, ec, ee ? 0 : 4);
      chk_near({nm, "_model_sin"}, m_sin, es, ee ? 0 : 4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int dones;
    int gaps;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    // start while reset is low must be ignored
    theta = 32'sh1921FB54;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_bit("rst_err", err, 1'b0);
    chk_near("rst_cos", longint'(cos_out), 0, 0);
    chk_near("rst_sin", longint'(sin_out), 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_angle("zero",     32'sh00000000, 64'sh40000000, 0,              1'b0);
    run_angle("pi4",      32'sh1921FB54, 64'sh2D413CCD, 64'sh2D413CCD, 1'b0);
    run_angle("pi2",      32'sh3243F6A9, 0,              64'sh40000000, 1'b0);
    run_angle("3pi4",     32'sh4B65F1FC, -64'sh2D413CCD, 64'sh2D413CCD, 1'b0);
    run_angle("neg_pi",   32'sh9B7812AF, -64'sh40000000, 0,             1'b0);
    run_angle("neg_pi4",  32'shE6DE04AC, 64'sh2D413CCD, -64'sh2D413CCD, 1'b0);
    run_angle("pos_pi",   32'sh6487ED51, -64'sh40000000, 0,             1'b0);
    run_angle("big",      32'sh70000000, 0,              0,             1'b1);
    run_angle("just_out", 32'sh6487ED52, 0,              0,             1'b1);
    run_angle("clear",    32'sh00000000, 64'sh40000000, 0,              1'b0);

    // Handshake: starts at relative cycles 1 and 5 are dropped, the one in the done cycle is taken.
    wait_idle();
    theta = 32'sh1921FB54;
    start = 1'b1;
    @(posedge clk); #1;          // accepting edge E; start stays high into E+1
    dones = 0;
    gaps  = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;        // just after edge E+k
      start = (k == 4) || (k == 25);
      if (done) dones++;
      if (((k >= 1 && k <= 24) || (k >= 26 && k <= 50)) && !busy) gaps++;
    end
    start = 1'b0;
    chk_int("hs_done_count", dones, 2);
    chk_int("hs_busy_gaps", gaps, 0);

    // Reset in the middle of a run
    wait_idle();
    theta = 32'sh3243F6A9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    chk_bit("mid_rst_busy", busy, 1'b0);
    chk_bit("mid_rst_done", done, 1'b0);
    chk_near("mid_rst_cos", longint'(cos_out), 0, 0);
    chk_near("mid_rst_sin", longint'(sin_out), 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    chk_bit("rst_start_ignored", busy, 1'b0);
    start = 1'b0;
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk_int("mid_rst_no_done", dones, 0);
    run_angle("after_rst", 32'sh1921FB54, 64'sh2D413CCD, 64'sh2D413CCD, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
